amp_step_ctrl: RTL and testbench
================================

// Module: amp_step_ctrl
// PURPOSE
//  Controller for the amplitude-adjust path. It sits between the EC11 encoder pulse outputs and the seg-LED/DAC side.
//  Arbitrates encoder steps against a host preset request and applies speed-dependent step size (acceleration).
//  Holds the amplitude in 0..MAX_VAL with saturation, and drives the BCD digits for the two seg-LEDs.
//  Pushes every committed value to the amplifier config interface over a valid/ready handshake, coalescing bursts.
// PARAMETERS
//  MAX_VAL    99      upper saturation limit, binary, 1..99
//  INIT_VAL   0       value loaded at reset, <= MAX_VAL
//  FAST_STEP  5       step size when accelerated, 1..MAX_VAL
//  ACCEL_WIN  600000  cycles (50 ms @ 12 MHz); same-direction pulse inside window => fast step
// PORTS
//  clk          in   1  system clock 12 MHz
//  rst          in   1  asynchronous, active-high reset
//  L_pulse      in   1  1-cycle left-turn pulse (decrement)
//  R_pulse      in   1  1-cycle right-turn pulse (increment)
//  preset_req   in   1  1-cycle host request to load preset_val
//  preset_val   in   7  binary preset value; clamped to MAX_VAL
//  cfg_ready    in   1  amplifier config sink accepts cfg_data
//  cfg_valid    out  1  cfg_data valid, held until accepted
//  cfg_data     out  7  binary amplitude for the amplifier
//  seg_data     out  8  BCD: [7:4] tens, [3:0] units
//  busy         out  1  config transfer in flight or pending
// BEHAVIOUR
//  Reset (async, active-high), all outputs registered:
//   value=INIT_VAL; seg_data=BCD(INIT_VAL); cfg_valid=0; cfg_data=0; busy=1.
//   pending=1, so the first cycle after release starts a transfer of INIT_VAL. Window timer cleared; last_dir=none.
//  Arbitration, per cycle, evaluated in this order:
//   1. preset_req: it wins. value=min(preset_val,MAX_VAL). Any L/R pulse in the same cycle is discarded. The window timer is cleared.
//   2. L_pulse&R_pulse together: both are ignored. Value and timer are unchanged.
//   3. L or R alone: step=FAST_STEP if the direction equals last_dir and the timer is <ACCEL_WIN, else step=1.
//      The timer is restarted to 0 and last_dir is updated.
//  Arithmetic: 8-bit internal. R: value=min(value+step,MAX_VAL). L: value=(value<step)?0:value-step.
//  Saturation: a pulse at a limit still restarts the timer. It sets pending only if the value changed.
//  Timer saturates at ACCEL_WIN and does not wrap.
//  Latency: pulse or preset at cycle N => value and seg_data updated at N+1. cfg_valid rises at N+2 if the FSM is IDLE.
//  Config FSM, states IDLE and SEND:
//   IDLE: if pending, then cfg_data<=value, cfg_valid<=1, pending<=0, go to SEND.
//   SEND: cfg_valid and cfg_data are held stable. On cfg_valid&cfg_ready, cfg_valid<=0 and go to IDLE.
//         IDLE re-launches next cycle if pending was set meanwhile.
//  Coalescing: changes during SEND set pending only. Only the latest value is sent next; intermediate values are dropped.
//   The final settled value is always transferred.
//  busy = (state==SEND) | pending.
//  Reset mid-transfer: cfg_valid drops asynchronously. After release, INIT_VAL is re-sent.
// STRUCTURE
//  Shared package amp_pkg: AMP_W=7, BCD_W=8, state enum {IDLE,SEND}, DIR_NONE/DIR_L/DIR_R.
//  One sub-module, amp_bin2bcd: combinational 7-bit binary -> 2-digit BCD (double-dabble).
//   Its output is registered in amp_step_ctrl to form seg_data.
//  Remainder lives in one file: arbiter, accel timer, value register, config FSM.
// TESTING
//  Reset, then hold cfg_ready=1 -> seg_data=8'h00, one transfer with cfg_data=0, then busy=0.
//  3 R_pulses 1000 cycles apart -> 0,1,6,11; seg_data 8'h11.
//   Next R after 700000 idle cycles -> 12.
//  Value 97, R twice within window -> 98 then 99 (saturated).
//   Then L,L fast -> 98, 93; seg_data 8'h93.
//  preset_req with preset_val=120 while R_pulse is also high -> value 99; R ignored.
//   L&R together -> no change, no transfer.
//  cfg_ready=0, 4 R pulses from 10 -> first transfer holds cfg_data=11 stable.
//   Raise cfg_ready -> exactly one more transfer with cfg_data=26. Then busy=0.
//  Assert rst during SEND -> cfg_valid=0 same cycle.
//   After release -> value=INIT_VAL and a fresh transfer of INIT_VAL.

Source files
------------

// File: rtl/amp_pkg.sv
// Shared types and widths for the amplitude-step controller.
package amp_pkg;
  localparam int AMP_W = 7;
  localparam int BCD_W = 8;

  typedef enum logic {IDLE, SEND} cfg_state_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_L = 2'd1, DIR_R = 2'd2} dir_t;

  // Constant-time BCD for reset values; the datapath uses amp_bin2bcd.
  function automatic logic [BCD_W-1:0] bcd_of(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/amp_bin2bcd.sv
// Combinational 7-bit binary to two-digit BCD (double-dabble); hundreds digit dropped.
module amp_bin2bcd
  import amp_pkg::*;
(
  input  logic [AMP_W-1:0] bin,
  output logic [BCD_W-1:0] bcd
);
  logic [AMP_W+BCD_W-1:0] sr;

  always_comb begin
    sr = {{BCD_W{1'b0}}, bin};
    for (int i = 0; i < AMP_W; i++) begin
      if (sr[AMP_W+3:AMP_W] >= 4'd5)     sr[AMP_W+3:AMP_W]   = sr[AMP_W+3:AMP_W] + 4'd3;
      if (sr[AMP_W+7:AMP_W+4] >= 4'd5)   sr[AMP_W+7:AMP_W+4] = sr[AMP_W+7:AMP_W+4] + 4'd3;
      sr = sr << 1;
    end
    bcd = sr[AMP_W+BCD_W-1:AMP_W];
  end
endmodule

// File: rtl/amp_step_ctrl.sv
// Encoder/preset arbiter with step acceleration, saturating amplitude register,
// BCD display register and a coalescing valid/ready push to the amplifier config.
module amp_step_ctrl
  import amp_pkg::*;
#(
  parameter int MAX_VAL   = 99,
  parameter int INIT_VAL  = 0,
  parameter int FAST_STEP = 5,
  parameter int ACCEL_WIN = 600000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             L_pulse,
  input  logic             R_pulse,
  input  logic             preset_req,
  input  logic [AMP_W-1:0] preset_val,
  input  logic             cfg_ready,
  output logic             cfg_valid,
  output logic [AMP_W-1:0] cfg_data,
  output logic [BCD_W-1:0] seg_data,
  output logic             busy
);
  localparam int               TMR_W    = $clog2(ACCEL_WIN + 1);
  localparam logic [TMR_W-1:0] WIN      = TMR_W'(ACCEL_WIN);
  localparam logic [7:0]       MAX8     = 8'(MAX_VAL);
  localparam logic [7:0]       FAST8    = 8'(FAST_STEP);
  localparam logic [7:0]       INIT8    = 8'(INIT_VAL);
  localparam logic [BCD_W-1:0] INIT_BCD = bcd_of(INIT_VAL);

  logic [7:0]       value, value_nxt, step, sum, preset_ext;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  dir_t             last_dir, dir_nxt, dir_in;
  logic             changed;
  logic [BCD_W-1:0] bcd_nxt;
  cfg_state_t       state, state_nxt;
  logic             pending, pend_nxt, launch, done;

  assign preset_ext = {1'b0, preset_val};

  always_comb begin
    value_nxt = value;
    dir_nxt   = last_dir;
    dir_in    = DIR_NONE;
    step      = 8'd1;
    sum       = '0;
    tmr_nxt   = (tmr == WIN) ? tmr : tmr + TMR_W'(1);
    if (preset_req) begin
      value_nxt = (preset_ext > MAX8) ? MAX8 : preset_ext;
      tmr_nxt   = '0;
    end else if (L_pulse && R_pulse) begin
      tmr_nxt = tmr;
    end else if (L_pulse || R_pulse) begin
      dir_in  = R_pulse ? DIR_R : DIR_L;
      step    = (dir_in == last_dir && tmr < WIN) ? FAST8 : 8'd1;
      tmr_nxt = '0;
      dir_nxt = dir_in;
      if (R_pulse) begin
        sum       = value + step;
        value_nxt = (sum > MAX8) ? MAX8 : sum;
      end else begin
        value_nxt = (value < step) ? 8'd0 : value - step;
      end
    end
  end

  assign changed = (value_nxt != value);

  // Convert the next value so seg_data lands in the same cycle as value.
  amp_bin2bcd u_bcd (
    .bin (value_nxt[AMP_W-1:0]),
    .bcd (bcd_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value    <= INIT8;
      seg_data <= INIT_BCD;
      tmr      <= '0;
      last_dir <= DIR_NONE;
    end else begin
      value    <= value_nxt;
      seg_data <= bcd_nxt;
      tmr      <= tmr_nxt;
      last_dir <= dir_nxt;
    end
  end

  // A change in the launch cycle must survive, since cfg_data takes the old value.
  always_comb begin
    launch    = (state == IDLE) && pending;
    done      = (state == SEND) && cfg_valid && cfg_ready;
    pend_nxt  = changed | (pending & ~launch);
    state_nxt = state;
    if (launch)    state_nxt = SEND;
    else if (done) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cfg_valid <= 1'b0;
      cfg_data  <= '0;
      pending   <= 1'b1;
      busy      <= 1'b1;
    end else begin
      state   <= state_nxt;
      pending <= pend_nxt;
      busy    <= (state_nxt == SEND) | pend_nxt;
      if (launch) begin
        cfg_valid <= 1'b1;
        cfg_data  <= value[AMP_W-1:0];
      end else if (done) begin
        cfg_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_amp_step_ctrl.sv
// Directed bench for amp_step_ctrl with a shortened acceleration window.
module tb_amp_step_ctrl;
  localparam int WIN = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       L_pulse = 1'b0, R_pulse = 1'b0, preset_req = 1'b0;
  logic [6:0] preset_val = '0;
  logic       cfg_ready = 1'b1;
  logic       cfg_valid;
  logic [6:0] cfg_data;
  logic [7:0] seg_data;
  logic       busy;

  int n_chk = 0, n_pass = 0;
  int xfer_cnt = 0, unstable = 0, snap = 0;
  logic [6:0] last_xfer = '0, hold_data = '0;
  logic       hold_seen = 1'b0;

  amp_step_ctrl #(.MAX_VAL(99), .INIT_VAL(0), .FAST_STEP(5), .ACCEL_WIN(WIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .L_pulse    (L_pulse),
    .R_pulse    (R_pulse),
    .preset_req (preset_req),
    .preset_val (preset_val),
    .cfg_ready  (cfg_ready),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .seg_data   (seg_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Handshake monitor: counts transfers and flags data changing while stalled.
  always @(posedge clk) begin
    if (!rst && cfg_valid && cfg_ready) begin
      xfer_cnt  = xfer_cnt + 1;
      last_xfer = cfg_data;
      hold_seen = 1'b0;
    end else if (!rst && cfg_valid) begin
      if (hold_seen && cfg_data != hold_data) unstable = unstable + 1;
      hold_seen = 1'b1;
      hold_data = cfg_data;
    end else begin
      hold_seen = 1'b0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic l, input logic r);
    @(negedge clk); L_pulse = l; R_pulse = r;
    @(negedge clk); L_pulse = 1'b0; R_pulse = 1'b0;
  endtask

  task automatic preset(input logic [6:0] v, input logic r);
    @(negedge clk); preset_req = 1'b1; preset_val = v; R_pulse = r;
    @(negedge clk); preset_req = 1'b0; R_pulse = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_data", cfg_data, 0);
    chk("rst_seg", seg_data, 8'h00);
    chk("rst_busy", busy, 1);
    rst = 1'b0;
    cyc(6);
    chk("init_xfers", xfer_cnt, 1);
    chk("init_xfer_val", last_xfer, 0);
    chk("init_idle", busy, 0);

    // Acceleration: slow first step, then fast inside the window, slow after expiry.
    pulse(0, 1); chk("r1_seg", seg_data, 8'h01);
    cyc(1000);
    pulse(0, 1); chk("r2_seg", seg_data, 8'h06);
    cyc(1000);
    pulse(0, 1); chk("r3_seg", seg_data, 8'h11);
    cyc(WIN + 100);
    pulse(0, 1); chk("r_slow_seg", seg_data, 8'h12);
    cyc(10);
    chk("r_slow_xfer", last_xfer, 12);
    chk("r_xfers", xfer_cnt, 5);

    // Upper saturation and fast decrement.
    preset(7'd97, 0); chk("pre97_seg", seg_data, 8'h97);
    cyc(WIN + 100);
    pulse(0, 1); chk("sat98_seg", seg_data, 8'h98);
    pulse(0, 1); chk("sat99_seg", seg_data, 8'h99);
    cyc(10);
    snap = xfer_cnt;
    pulse(0, 1); chk("sat_hold_seg", seg_data, 8'h99);
    cyc(10);
    chk("sat_no_xfer", xfer_cnt, snap);
    pulse(1, 0); chk("l98_seg", seg_data, 8'h98);
    pulse(1, 0); chk("l93_seg", seg_data, 8'h93);
    cyc(10);
    chk("l93_xfer", last_xfer, 93);
    chk("l93_idle", busy, 0);

    // Preset wins over a simultaneous R and clamps; L&R together is a no-op.
    preset(7'd120, 1); chk("clamp_seg", seg_data, 8'h99);
    cyc(10);
    chk("clamp_xfer", last_xfer, 99);
    snap = xfer_cnt;
    pulse(1, 1); chk("lr_seg", seg_data, 8'h99);
    cyc(10);
    chk("lr_no_xfer", xfer_cnt, snap);

    // Coalescing while the sink stalls.
    preset(7'd10, 0);
    cyc(WIN + 100);
    snap = xfer_cnt;
    cfg_ready = 1'b0;
    pulse(0, 1); pulse(0, 1); pulse(0, 1); pulse(0, 1);
    chk("coal_seg", seg_data, 8'h26);
    chk("coal_valid", cfg_valid, 1);
    chk("coal_hold_data", cfg_data, 11);
    chk("coal_busy", busy, 1);
    cfg_ready = 1'b1;
    cyc(10);
    chk("coal_xfers", xfer_cnt - snap, 2);
    chk("coal_last", last_xfer, 26);
    chk("coal_idle", busy, 0);
    chk("hold_stable", unstable, 0);

    // Reset in the middle of a transfer.
    cfg_ready = 1'b0;
    pulse(0, 1);
    cyc(1);
    chk("mid_valid", cfg_valid, 1);
    snap = xfer_cnt;
    #1 rst = 1'b1;
    #1 chk("rst_async_valid", cfg_valid, 0);
    chk("rst_async_seg", seg_data, 8'h00);
    cyc(2);
    rst = 1'b0;
    cfg_ready = 1'b1;
    cyc(6);
    chk("rerst_xfers", xfer_cnt - snap, 1);
    chk("rerst_xfer_val", last_xfer, 0);
    chk("rerst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
